// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extend unit: mode encodings and default widths.
// Optional overflow flag is controlled by IMMX_OVF_EN in the core and top files.
package imm_ext_pkg;

    localparam int IMM_W_DEFAULT = 17;
    localparam int WORD_W        = 32;

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'd0,
        MODE_ZEXT     = 2'd1,
        MODE_SEXT_SHL = 2'd2,
        MODE_UPPER    = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_extend_unit_core.sv
// Pure combinational extend/shift function for the immediate extend unit.
// With IMMX_OVF_EN defined, also flags mode-2 results whose signed offset is unrepresentable.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = IMM_W_DEFAULT,
    parameter int OUT_W    = WORD_W,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data
`ifdef IMMX_OVF_EN
    ,
    output logic             ovf
`endif
);

    imm_mode_e        mode_e;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] shl;

    assign mode_e = imm_mode_e'(mode);

    // Equal widths must not produce zero-width replications, so that case is split out.
    generate
        if (IN_W == OUT_W) begin : g_full
            assign sext  = imm;
            assign zext  = imm;
            assign upper = imm;
        end else begin : g_ext
            logic s;
            assign s     = imm[IN_W-1];
            assign sext  = {{(OUT_W-IN_W){s}}, imm};
            assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
            assign upper = {imm, {(OUT_W-IN_W){1'b0}}};
        end
    endgenerate

    assign shl = sext << BR_SHIFT;

    always_comb begin
        data = '0;
        unique case (mode_e)
            MODE_SEXT:     data = sext;
            MODE_ZEXT:     data = zext;
            MODE_SEXT_SHL: data = shl;
            MODE_UPPER:    data = upper;
            default:       data = '0;
        endcase
    end

`ifdef IMMX_OVF_EN
    // Bits shifted out plus the new MSB must all match the original sign bit.
    localparam int               HI_POS  = OUT_W - 1 - BR_SHIFT;
    localparam logic [OUT_W-1:0] HI_ONES = {OUT_W{1'b1}} >> HI_POS;

    logic [OUT_W-1:0] hi_bits;
    logic [OUT_W-1:0] hi_want;

    assign hi_bits = sext >> HI_POS;
    assign hi_want = sext[OUT_W-1] ? HI_ONES : '0;
    assign ovf     = (mode_e == MODE_SEXT_SHL) && (hi_bits != hi_want);
`endif

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extend unit: combinational extender feeding a DEPTH-entry valid/ready FIFO.
// Define IMMX_OVF_EN to add the per-entry branch-offset overflow flag and out_ovf port.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = IMM_W_DEFAULT,
    parameter int OUT_W    = WORD_W,
    parameter int BR_SHIFT = 2,
    parameter int DEPTH    = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef IMMX_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
`ifdef IMMX_OVF_EN
    logic             mem_ovf  [DEPTH];
    logic             ext_ovf;
`endif

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] ext_data;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
`ifdef IMMX_OVF_EN
        ,
        .ovf  (ext_ovf)
`endif
    );

    assign out_valid = (count != '0);
    // A pop in the same cycle frees a slot, allowing full-rate streaming when full.
    assign in_ready  = (count < CW'(DEPTH)) || (out_valid && out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];
`ifdef IMMX_OVF_EN
    assign out_ovf   = mem_ovf[rd_ptr];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[PW'(i)] <= '0;
                mem_tag[PW'(i)]  <= '0;
`ifdef IMMX_OVF_EN
                mem_ovf[PW'(i)]  <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= ext_data;
                mem_tag[wr_ptr]  <= in_tag;
`ifdef IMMX_OVF_EN
                mem_ovf[wr_ptr]  <= ext_ovf;
`endif
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench: directed tests on a default instance, random sweep on a 32/32/DEPTH=4 instance.
// Overflow-flag checks are compiled in when IMMX_OVF_EN is defined.
module tb_imm_extend_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [16:0] a_in_imm;
    logic [1:0]  a_in_mode;
    logic [4:0]  a_in_tag, a_out_tag;
    logic [31:0] a_out_data;
`ifdef IMMX_OVF_EN
    logic        a_out_ovf;
`endif

    // IN_W=OUT_W=32, DEPTH=4 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic [4:0]  b_in_tag, b_out_tag;
    logic [31:0] b_out_data;
`ifdef IMMX_OVF_EN
    logic        b_out_ovf;
`endif

    imm_extend_unit u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_imm    (a_in_imm),
        .in_mode   (a_in_mode),
        .in_tag    (a_in_tag),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_tag   (a_out_tag)
`ifdef IMMX_OVF_EN
        ,
        .out_ovf   (a_out_ovf)
`endif
    );

    imm_extend_unit #(
        .IN_W     (32),
        .OUT_W    (32),
        .BR_SHIFT (2),
        .DEPTH    (4),
        .TAG_W    (5)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_imm    (b_in_imm),
        .in_mode   (b_in_mode),
        .in_tag    (b_in_tag),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_tag   (b_out_tag)
`ifdef IMMX_OVF_EN
        ,
        .out_ovf   (b_out_ovf)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        bit          o;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret the immediate as a signed/unsigned integer and do plain arithmetic modulo 2^out_w.
    function automatic longint ref_ext(input longint imm, input int mode, input int in_w,
                                       input int out_w, input int sh, output bit ovf);
        longint v, r, m, half;
        m    = longint'(1) << out_w;
        half = m / 2;
        v    = imm;
        if (imm >= (longint'(1) << (in_w - 1))) v = imm - (longint'(1) << in_w);
        ovf = 1'b0;
        case (mode)
            0: r = v;
            1: r = imm;
            2: begin
                r   = v * (longint'(1) << sh);
                ovf = (r < -half) || (r >= half);
            end
            default: r = imm * (longint'(1) << (out_w - in_w));
        endcase
        r = r % m;
        if (r < 0) r += m;
        return r;
    endfunction

    logic [16:0] vimm  [5];
    logic [1:0]  vmode [5];
    logic [31:0] vexp  [5];

    initial begin
        longint exp_d;
        bit     exp_o;
        bit     exp_ready, do_push, do_pop;
        ent_t   e;
        logic [31:0] corner [8];

        corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                   32'hFFFFFFFF, 32'h40000000, 32'h20000000, 32'hDFFFFFFF};

        vimm[0] = 17'd10455;   vmode[0] = 2'd0; vexp[0] = 32'h000028D7;
        vimm[1] = 17'h1D729;   vmode[1] = 2'd0; vexp[1] = 32'hFFFFD729;
        vimm[2] = 17'h1D729;   vmode[2] = 2'd1; vexp[2] = 32'h0001D729;
        vimm[3] = 17'd10455;   vmode[3] = 2'd3; vexp[3] = 32'h146B8000;
        vimm[4] = 17'h1D729;   vmode[4] = 2'd2; vexp[4] = 32'hFFFF5CA4;

        a_in_valid = 0; a_out_ready = 0; a_in_imm = '0; a_in_mode = '0; a_in_tag = '0;
        b_in_valid = 0; b_out_ready = 0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0;

        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_data",  a_out_data,  0);
        chk("reset_out_tag",   a_out_tag,   0);
        chk("reset_in_ready",  a_in_ready,  1);
`ifdef IMMX_OVF_EN
        chk("reset_out_ovf",   a_out_ovf,   0);
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("idle_out_valid", a_out_valid, 0);

        // Directed arithmetic, one push at a time, consumer always ready
        a_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            a_in_imm = vimm[i]; a_in_mode = vmode[i]; a_in_tag = 5'(i + 10); a_in_valid = 1;
            tick();
            a_in_valid = 0;
            chk("vec_out_valid", a_out_valid, 1);
            chk($sformatf("vec%0d_out_data", i), a_out_data, vexp[i]);
            chk("vec_out_tag", a_out_tag, 5'(i + 10));
`ifdef IMMX_OVF_EN
            chk("vec_out_ovf", a_out_ovf, 0);
`endif
            tick();
            chk("vec_popped", a_out_valid, 0);
        end

        // Backpressure and ordering
        a_out_ready = 0;
        a_in_imm = 17'd100; a_in_mode = 2'd0; a_in_tag = 5'd1; a_in_valid = 1;
        tick();
        a_in_imm = 17'd200; a_in_tag = 5'd2;
        tick();
        a_in_valid = 0;
        #1;
        chk("bp_in_ready_full", a_in_ready, 0);
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_out_tag", a_out_tag, 1);
        tick();
        chk("bp_out_tag_held", a_out_tag, 1);
        chk("bp_out_data_held", a_out_data, 32'd100);
        a_out_ready = 1; a_in_imm = 17'd300; a_in_tag = 5'd3; a_in_valid = 1;
        #1;
        chk("bp_in_ready_passthru", a_in_ready, 1);
        tick();
        a_in_valid = 0; a_out_ready = 0;
        #1;
        chk("bp_count_still_full", a_in_ready, 0);
        chk("bp_order_tag2", a_out_tag, 2);
        chk("bp_order_data2", a_out_data, 32'd200);
        a_out_ready = 1;
        tick();
        chk("bp_order_tag3", a_out_tag, 3);
        chk("bp_order_data3", a_out_data, 32'd300);
        tick();
        chk("bp_drained", a_out_valid, 0);

        // Asynchronous reset mid-operation with the FIFO full
        a_out_ready = 0;
        a_in_imm = 17'd7; a_in_tag = 5'd7; a_in_valid = 1;
        tick();
        a_in_tag = 5'd8;
        tick();
        a_in_valid = 0;
        #1;
        chk("rst_pre_full", a_in_ready, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_out_valid", a_out_valid, 0);
        chk("rst_async_in_ready", a_in_ready, 1);
        chk("rst_async_out_tag", a_out_tag, 0);
        chk("rst_async_out_data", a_out_data, 0);
        #1 rst = 1'b1;
        a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_stale", a_out_valid, 0);
        end
        a_in_imm = 17'd5; a_in_mode = 2'd0; a_in_tag = 5'd9; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        chk("rst_new_valid", a_out_valid, 1);
        chk("rst_new_tag", a_out_tag, 9);
        chk("rst_new_data", a_out_data, 5);
        tick();

        // Random sweep on the 32/32/DEPTH=4 instance against a queue model
        q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            chk("rnd_out_valid", b_out_valid, (q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_out_data", b_out_data, q[0].d);
                chk("rnd_out_tag", b_out_tag, q[0].t);
`ifdef IMMX_OVF_EN
                chk("rnd_out_ovf", b_out_ovf, q[0].o);
`endif
            end
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ((cyc / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            b_in_imm    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            b_in_mode   = 2'($urandom_range(0, 3));
            b_in_tag    = 5'($urandom_range(0, 31));
            #1;
            exp_ready = (q.size() < 4) || ((q.size() != 0) && b_out_ready);
            chk("rnd_in_ready", b_in_ready, exp_ready);
            do_push = b_in_valid && exp_ready;
            do_pop  = (q.size() != 0) && b_out_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                exp_d = ref_ext(longint'(b_in_imm), int'(b_in_mode), 32, 32, 2, exp_o);
                e.d = exp_d[31:0];
                e.t = b_in_tag;
                e.o = exp_o;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end

        // Drain, then directed mode-2 corner cases at full width
        b_in_valid = 0; b_out_ready = 1;
        for (int i = 0; i < 5; i++) tick();
        q.delete();
        chk("b_drained", b_out_valid, 0);
        b_in_imm = 32'h40000000; b_in_mode = 2'd2; b_in_tag = 5'd4; b_in_valid = 1;
        tick();
        chk("b_shl_big_data", b_out_data, 32'h0);
`ifdef IMMX_OVF_EN
        chk("b_shl_big_ovf", b_out_ovf, 1);
`endif
        b_in_imm = 32'h1;
        tick();
        b_in_valid = 0;
        chk("b_shl_one_data", b_out_data, 32'h4);
        chk("b_shl_one_tag", b_out_tag, 4);
`ifdef IMMX_OVF_EN
        chk("b_shl_one_ovf", b_out_ovf, 0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Parametrised successor to the fixed 17-to-32 sign extender in the KGP RISC datapath.
- Takes an IN_W-bit immediate field and a 2-bit mode, and produces an OUT_W-bit operand.
- Supported modes: sign-extend, zero-extend, sign-extend with left shift (branch offsets), and upper placement (LUI-style).
- Results are buffered in a DEPTH-entry elastic FIFO with valid/ready handshakes on both sides, so decode and execute can stall independently.

Parameters:
- IN_W, 17, immediate input width; 1 <= IN_W <= OUT_W.
- OUT_W, 32, output operand width.
- BR_SHIFT, 2, left-shift amount for mode 2; 0 <= BR_SHIFT < OUT_W.
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- TAG_W, 5, sideband tag width (destination register id), carried unmodified.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept this cycle.
- in_imm  in  IN_W  immediate field.
- in_mode  in  2  0=SEXT, 1=ZEXT, 2=SEXT_SHL, 3=UPPER.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  OUT_W  extended operand at FIFO head.
- out_tag  out  TAG_W  tag at FIFO head.
- out_ovf  out  1  only present with IMMX_OVF_EN.

Behaviour:
- Reset (rst low, asynchronous):
  - Write pointer, read pointer and count clear to 0.
  - out_valid=0, out_data=0, out_tag=0, out_ovf=0.
  - FIFO storage contents are don't-care.
  - Any in-flight entry is discarded; nothing is emitted after rst releases until a new push.
- Push: occurs when in_valid && in_ready. The extended result is computed combinationally and written into the FIFO entry at the write pointer on that clock edge.
- Pop: occurs when out_valid && out_ready; the read pointer advances.
- Latency: a push at edge N makes the entry visible at the FIFO head after edge N. If the FIFO was empty, out_valid=1 in cycle N+1. There is no combinational in-to-out path.
- Ready rule: in_ready = (count < DEPTH) || (out_valid && out_ready).
  - This gives one-cycle full-rate throughput.
  - in_ready depends combinationally on out_ready; this is permitted.
- out_valid = (count != 0). out_data, out_tag and out_ovf come from the head entry, registered storage only.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full and when count==1.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Push when full without a same-cycle pop cannot happen, because in_ready=0. in_valid is ignored in that case.
- out_data is held stable while out_valid && !out_ready.
- Arithmetic, with s = in_imm[IN_W-1]:
  - Mode 0 (SEXT): {(OUT_W-IN_W) copies of s, in_imm}.
  - Mode 1 (ZEXT): {(OUT_W-IN_W) zeros, in_imm}.
  - Mode 2 (SEXT_SHL): the mode-0 value shifted left by BR_SHIFT, zero fill; the top BR_SHIFT bits are dropped.
  - Mode 3 (UPPER): {in_imm, (OUT_W-IN_W) zeros}. When IN_W==OUT_W, this equals in_imm.
- The IN_W==OUT_W case must elaborate without zero-width replication errors; modes 0 and 1 then pass in_imm through.
- in_tag is stored with the result and returned unchanged.

Optional Feature:
- Macro: IMMX_OVF_EN.
- Defined:
  - Port out_ovf exists, with one stored bit per entry.
  - The bit is set on push only in mode 2, when the BR_SHIFT bits shifted out of the mode-0 value plus the new MSB are not all equal to s (the signed offset is unrepresentable).
  - In all other modes the bit is 0. It resets to 0.
- Undefined: the port and storage bit are absent, and there is no other behavioural change.

Decomposition:
- Shared package imm_ext_pkg holds:
  - the mode encodings MODE_SEXT=0, MODE_ZEXT=1, MODE_SEXT_SHL=2, MODE_UPPER=3;
  - the mode typedef (2-bit);
  - the default widths IMM_W_DEFAULT=17 and WORD_W=32.
- One natural sub-module, imm_ext_core, holds the pure combinational extend/shift/overflow function. The top level holds the FIFO, pointers, count and handshake.

Test Plan:
- Defaults, mode 0, in_imm=10455, out_ready=1 -> cycle+1: out_valid=1, out_data=32'h000028D7 (10455). Then in_imm=-10455 (17'h1D729) -> out_data=32'hFFFFD729.
- Mode 1, in_imm=17'h1D729 -> out_data=32'h0001D729 (120617). Mode 3, in_imm=10455 -> out_data=32'h146B8000.
- Mode 2, in_imm=-10455 -> out_data=32'hFFFF5CA4. With IMMX_OVF_EN and IN_W=OUT_W=32, in_imm=32'h40000000 in mode 2 -> out_ovf=1; in_imm=1 in mode 2 -> out_ovf=0.
- Backpressure and ordering:
  - Hold out_ready=0 and push tags 1,2 -> in_ready=0 after 2 pushes, out_tag=1 held stable.
  - Then out_ready=1 with in_valid=1 -> push and pop in the same cycle, count stays 2.
  - Pops return tags 1,2,3 in order.
- Reset mid-operation: with 2 entries full, pulse rst low asynchronously between edges -> out_valid=0 immediately, in_ready=1. After release, no stale entry is emitted.
- Parameter sweep with IN_W=32, OUT_W=32, DEPTH=4: run 1000 random pushes and pops against a reference model -> zero mismatches, and no in_ready deassertion with fewer than 4 entries.
